// File: rtl/fft_input_deserializer.sv
// Serial-to-parallel input stage for the FFT datapath: stream in one complex sample per
// cycle, buffer in a small FIFO, and present SEG_COUNT samples as one held parallel frame.
module fft_input_deserializer #(
    parameter int DATA_WIDTH = 32,
    parameter int SEG_COUNT  = 8,
    parameter int BUF_DEPTH  = 3
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            flush,
    input  logic                            mode,
    input  logic                            bitrev,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [DATA_WIDTH-1:0]           in_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [SEG_COUNT*DATA_WIDTH-1:0] out_data,
    output logic [$clog2(SEG_COUNT):0]      fill_level
);

    localparam int HALF    = DATA_WIDTH / 2;
    localparam int LOG_SEG = $clog2(SEG_COUNT);
    localparam int LVL_W   = LOG_SEG + 1;
    localparam int PTR_W   = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W   = $clog2(BUF_DEPTH + 1);

    localparam logic [0:0] ST_FILL = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    logic [DATA_WIDTH-1:0]           fifo_mem [BUF_DEPTH];
    logic [PTR_W-1:0]                wr_ptr;
    logic [PTR_W-1:0]                rd_ptr;
    logic [CNT_W-1:0]                fifo_count;
    logic [0:0]                      state;
    logic [DATA_WIDTH-1:0]           frame      [SEG_COUNT];
    logic [DATA_WIDTH-1:0]           frame_next [SEG_COUNT];
    logic                            bitrev_q;
    logic                            bitrev_next;
    logic [SEG_COUNT*DATA_WIDTH-1:0] out_next;
    logic                            push;
    logic                            pop;
    logic                            handshake;
    logic [DATA_WIDTH-1:0]           push_data;
    logic [DATA_WIDTH-1:0]           pop_data;

    // Circular wrap that works for non-power-of-two depths.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [LOG_SEG-1:0] bit_reverse(input logic [LOG_SEG-1:0] k);
        logic [LOG_SEG-1:0] r;
        for (int i = 0; i < LOG_SEG; i++) r[i] = k[LOG_SEG-1-i];
        return r;
    endfunction

    assign in_ready  = (fifo_count < CNT_W'(BUF_DEPTH)) && !rst;
    assign push      = in_valid && in_ready && !flush;
    assign pop       = (state == ST_FILL) && (fifo_count != '0) && !flush;
    assign handshake = (state == ST_HOLD) && out_ready;
    assign push_data = mode ? {in_data[HALF-1:0], in_data[DATA_WIDTH-1:HALF]} : in_data;
    assign pop_data  = fifo_mem[rd_ptr];
    assign out_valid = (state == ST_HOLD);

    // Next frame contents and its permuted view, so out_data can be a plain register.
    always_comb begin
        frame_next  = frame;
        bitrev_next = bitrev_q;
        out_next    = '0;
        if (pop) begin
            for (int k = 0; k < SEG_COUNT - 1; k++) frame_next[k] = frame[k+1];
            frame_next[SEG_COUNT-1] = pop_data;
            if (fill_level == '0) bitrev_next = bitrev;
        end
        for (int k = 0; k < SEG_COUNT; k++) begin
            out_next[k*DATA_WIDTH +: DATA_WIDTH] =
                bitrev_next ? frame_next[bit_reverse(LOG_SEG'(k))] : frame_next[k];
        end
    end

    // NOTE: the FIFO storage has no reset; fifo_count gates every read, so stale entries are never observed.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            state      <= ST_FILL;
            fill_level <= '0;
            bitrev_q   <= 1'b0;
            out_data   <= '0;
            for (int k = 0; k < SEG_COUNT; k++) frame[k] <= '0;
        end else if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            state      <= ST_FILL;
            fill_level <= '0;
            bitrev_q   <= 1'b0;
            out_data   <= '0;
            for (int k = 0; k < SEG_COUNT; k++) frame[k] <= '0;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            if (push && !pop)      fifo_count <= fifo_count + 1'b1;
            else if (pop && !push) fifo_count <= fifo_count - 1'b1;

            if (pop) begin
                frame      <= frame_next;
                bitrev_q   <= bitrev_next;
                out_data   <= out_next;
                fill_level <= fill_level + 1'b1;
                if (fill_level == LVL_W'(SEG_COUNT - 1)) state <= ST_HOLD;
            end else if (handshake) begin
                state      <= ST_FILL;
                fill_level <= '0;
            end
        end
    end

endmodule
